// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_pkg;

    localparam int unsigned APB_ADDR_WIDTH = 32;
    localparam int unsigned APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Bit width able to hold 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first valid request after i_last_grant, wrapping.
module apb_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
    output logic                       o_any_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_valid = 1'b0;
        w_cand      = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_last_grant) + k) % NUM_REQ);
            if (!o_any_valid && i_req[w_cand]) begin
                o_any_valid     = 1'b1;
                o_grant_idx     = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, SETUP/ACCESS sequencing,
// bounded PREADY wait, registered one-cycle response back to the granted requester.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESET,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_WIDTH-1:0]         PADDR,
    output logic [DATA_WIDTH-1:0]         PWDATA,
    input  logic [DATA_WIDTH-1:0]         PRDATA,
    input  logic                          PREADY,
    input  logic                          PSLVERR
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);

    apb_state_e             r_state;
    apb_state_e             w_state_nxt;
    logic [IDX_W-1:0]       r_last_grant;
    logic [CNT_W-1:0]       r_wait_cnt;
    logic                   r_psel;
    logic                   r_penable;
    logic                   r_pwrite;
    logic [ADDR_WIDTH-1:0]  r_paddr;
    logic [DATA_WIDTH-1:0]  r_pwdata;
    logic [NUM_REQ-1:0]     r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_rdata;
    logic                   r_rsp_err;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any_valid;
    logic                   w_timeout;
    logic                   w_finish;
    logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [NUM_REQ];

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any_valid  (w_any_valid)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, accept pulse and ACCESS termination conditions.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid && !PRESET) begin
                    req_ready   = w_grant;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ACCESS;
            end
            ACCESS: begin
                w_timeout = !PREADY && (TIMEOUT != 0) &&
                            ((32'(r_wait_cnt) + 32'd1) == TIMEOUT);
                w_finish  = PREADY || w_timeout;
                if (w_finish) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus drive, capture, wait counting and response registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_wait_cnt   <= '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_last_grant <= w_grant_idx;
                        r_wait_cnt   <= '0;
                        r_psel       <= 1'b1;
                        r_penable    <= 1'b0;
                        r_pwrite     <= req_write[w_grant_idx];
                        r_paddr      <= w_addr_arr[w_grant_idx];
                        r_pwdata     <= req_write[w_grant_idx] ? w_wdata_arr[w_grant_idx] : '0;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (w_finish) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_pwrite    <= 1'b0;
                        r_paddr     <= '0;
                        r_pwdata    <= '0;
                        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
                        r_rsp_rdata <= (PREADY && !r_pwrite) ? PRDATA : '0;
                        r_rsp_err   <= PREADY ? PSLVERR : 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grant order, latency and response data.
module tb_apb_master_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                 PCLK = 1'b0;
    logic                 PRESET;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_write;
    logic [NR*AW-1:0]     req_addr;
    logic [NR*DW-1:0]     req_wdata;
    logic [NR-1:0]        req_ready;
    logic [NR-1:0]        rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [AW-1:0]        PADDR;
    logic [DW-1:0]        PWDATA;
    logic [DW-1:0]        PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    int checks = 0;
    int errors = 0;
    int model_last = NR - 1;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]         = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Rotate the request mask so the slot after the last winner sits at bit 0, take the lowest set bit.
    function automatic int exp_grant(input logic [NR-1:0] mask, input int last);
        logic [2*NR-1:0] dbl;
        int s;
        s   = (last + 1) % NR;
        dbl = {mask, mask} >> s;
        for (int j = 0; j < NR; j++) begin
            if (dbl[j]) return (s + j) % NR;
        end
        return -1;
    endfunction

    task automatic test_reset();
        PRESET = 1'b1; req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if ({PSEL, PENABLE, PWRITE, rsp_err} !== 4'b0000 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got sel/en/wr/err=%b%b%b%b rsp_valid=%b want all 0", PSEL, PENABLE, PWRITE, rsp_err, rsp_valid); end
        checks++; if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h want 0", PADDR, PWDATA, rsp_rdata); end
        PRESET = 1'b0; req_valid = '0; model_last = NR - 1;
        tick();
    endtask

    task automatic test_single_read();
        set_req(0, 1'b0, 32'h10, 32'h1111_1111);
        req_valid = 4'b0001; PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rd_accept got %b want 0001", req_ready); end
        tick(); req_valid = '0; #1;
        checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h10 || PWDATA !== 32'h0) begin
            errors++; $display("FAIL rd_setup got sel/en/wr=%b%b%b paddr=%h pwdata=%h want 100/10/0", PSEL, PENABLE, PWRITE, PADDR, PWDATA); end
        tick(); #1;
        checks++; if ({PSEL, PENABLE} !== 2'b11 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL rd_access got sel/en=%b%b rsp_valid=%b want 11/0000", PSEL, PENABLE, rsp_valid); end
        tick(); PREADY = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rd_rsp got valid=%b rdata=%h err=%b want 0001/deadbeef/0", rsp_valid, rsp_rdata, rsp_err); end
        checks++; if (PSEL !== 1'b0 || PADDR !== 32'h0) begin
            errors++; $display("FAIL rd_idle_bus got psel=%b paddr=%h want 0/0", PSEL, PADDR); end
        model_last = 0;
        tick();
    endtask

    task automatic test_write_wait();
        set_req(2, 1'b1, 32'h24, 32'hA5A5_A5A5);
        req_valid = 4'b0100; PREADY = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wr_accept got %b want 0100", req_ready); end
        tick(); req_valid = '0; set_req(2, 1'b0, 32'hFFFF_FFFF, 32'h0); #1;
        checks++; if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 32'h24 || PWDATA !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL wr_setup got sel/en/wr=%b%b%b paddr=%h pwdata=%h want 101/24/a5a5a5a5", PSEL, PENABLE, PWRITE, PADDR, PWDATA); end
        for (int k = 0; k < 3; k++) begin
            tick(); PREADY = (k == 2); PRDATA = 32'h5555_0000 + k; #1;
            checks++; if ({PSEL, PENABLE} !== 2'b11 || PWDATA !== 32'hA5A5_A5A5 || PADDR !== 32'h24 || rsp_valid !== 4'b0000) begin
                errors++; $display("FAIL wr_access k=%0d got sel/en=%b%b pwdata=%h paddr=%h rsp=%b", k, PSEL, PENABLE, PWDATA, PADDR, rsp_valid); end
        end
        tick(); PREADY = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL wr_rsp got valid=%b rdata=%h err=%b want 0100/0/0", rsp_valid, rsp_rdata, rsp_err); end
        model_last = 2;
        tick();
    endtask

    task automatic test_fairness();
        PRESET = 1'b1; tick(); PRESET = 1'b0; model_last = NR - 1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
        req_valid = '1; PREADY = 1'b1; PSLVERR = 1'b0;
        for (int c = 0; c < 15; c++) begin
            logic [NR-1:0] exp_rdy;
            exp_rdy = (c % 3 == 0) ? (NR'(1) << ((c / 3) % NR)) : '0;
            #1;
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL fair_ready c=%0d got %b want %b", c, req_ready, exp_rdy); end
            if (c % 3 == 1) begin
                checks++; if (PADDR !== 32'h100 + 32'(4 * ((c / 3) % NR))) begin
                    errors++; $display("FAIL fair_paddr c=%0d got %h want %h", c, PADDR, 32'h100 + 32'(4 * ((c / 3) % NR))); end
            end
            tick();
        end
        req_valid = '0; PREADY = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL fair_last_rsp got %b want 0001", rsp_valid); end
        model_last = 0;
        tick();
    endtask

    task automatic test_slverr();
        set_req(1, 1'b0, 32'h40, 32'h0);
        req_valid = 4'b0010; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL err_accept got %b want 0010", req_ready); end
        tick(); req_valid = '0;
        tick(); PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFE_F00D;
        tick(); PREADY = 1'b0; PSLVERR = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b1) begin
            errors++; $display("FAIL err_rsp got valid=%b rdata=%h err=%b want 0010/cafef00d/1", rsp_valid, rsp_rdata, rsp_err); end
        model_last = 1;
        tick();
    endtask

    task automatic test_timeout();
        set_req(3, 1'b0, 32'h30, 32'h0);
        req_valid = 4'b1000; PREADY = 1'b0; #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_accept got %b want 1000", req_ready); end
        tick(); req_valid = '0;
        tick();
        for (int k = 0; k < TO; k++) begin
            #1;
            checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL to_wait k=%0d got sel/en=%b%b want 11", k, PSEL, PENABLE); end
            tick();
        end
        PRDATA = 32'h7777_7777; PREADY = 1'b1; #1;
        checks++; if ({PSEL, PENABLE} !== 2'b00) begin errors++; $display("FAIL to_drop got sel/en=%b%b want 00", PSEL, PENABLE); end
        checks++; if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL to_rsp got valid=%b err=%b rdata=%h want 1000/1/0", rsp_valid, rsp_err, rsp_rdata); end
        tick(); #1;
        checks++; if (rsp_valid !== 4'b0000 || PSEL !== 1'b0) begin
            errors++; $display("FAIL to_late_ready got rsp_valid=%b psel=%b want 0000/0", rsp_valid, PSEL); end
        PREADY = 1'b0; model_last = 3;
        set_req(0, 1'b0, 32'h34, 32'h0);
        req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lim_accept got %b want 0001", req_ready); end
        tick(); req_valid = '0;
        tick();
        for (int k = 0; k < TO; k++) begin
            PREADY = (k == TO - 1); PRDATA = 32'h1234; PSLVERR = 1'b0; #1;
            checks++; if ({PSEL, PENABLE} !== 2'b11) begin errors++; $display("FAIL lim_wait k=%0d got sel/en=%b%b want 11", k, PSEL, PENABLE); end
            tick();
        end
        PREADY = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h1234) begin
            errors++; $display("FAIL lim_rsp got valid=%b err=%b rdata=%h want 0001/0/1234", rsp_valid, rsp_err, rsp_rdata); end
        model_last = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_req(1, 1'b1, 32'h50, 32'h9999_9999);
        req_valid = 4'b0010; PREADY = 1'b0; #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_accept got %b want 0010", req_ready); end
        tick(); req_valid = '0;
        tick();
        tick(); PRESET = 1'b1; req_valid = '1; #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_gate got %b want 0000", req_ready); end
        tick();
        checks++; if ({PSEL, PENABLE, PWRITE, rsp_err} !== 4'b0000 || PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL rst_outputs got sel/en/wr/err=%b%b%b%b paddr=%h pwdata=%h rsp=%b", PSEL, PENABLE, PWRITE, rsp_err, PADDR, PWDATA, rsp_valid); end
        PRESET = 1'b0; #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rst_regrant got %b want 0001", req_ready); end
        tick(); req_valid = '0;
        tick(); PREADY = 1'b1;
        tick(); PREADY = 1'b0; #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++; $display("FAIL rst_rsp got %b want 0001", rsp_valid); end
        model_last = 0;
        tick();
    endtask

    task automatic test_random();
        int g, pg, waits;
        logic pend, p_err, w, err;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd, p_rdata;
        logic [NR-1:0] mask, exp_rsp;
        pend = 1'b0; pg = 0; p_err = 1'b0; p_rdata = '0;
        for (int it = 0; it < 40; it++) begin
            mask = NR'($urandom);
            for (int i = 0; i < NR; i++) set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
            req_valid = mask; PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            #1;
            exp_rsp = pend ? (NR'(1) << pg) : '0;
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rnd_rsp_valid it=%0d got %b want %b", it, rsp_valid, exp_rsp); end
            if (pend) begin
                checks++; if (rsp_rdata !== p_rdata || rsp_err !== p_err) begin
                    errors++; $display("FAIL rnd_rsp_data it=%0d got %h/%b want %h/%b", it, rsp_rdata, rsp_err, p_rdata, p_err); end
            end
            pend = 1'b0;
            if (mask == '0) begin
                checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rnd_idle it=%0d got %b want 0000", it, req_ready); end
                tick();
                continue;
            end
            g = exp_grant(mask, model_last);
            model_last = g;
            w = req_write[g]; a = req_addr[g*AW +: AW]; d = req_wdata[g*DW +: DW];
            checks++; if (req_ready !== (NR'(1) << g)) begin errors++; $display("FAIL rnd_ready it=%0d got %b want %b", it, req_ready, NR'(1) << g); end
            tick();
            req_valid = NR'($urandom); req_addr = {$urandom, $urandom, $urandom, $urandom}; PREADY = 1'($urandom);
            #1;
            checks++; if ({PSEL, PENABLE, PWRITE} !== {2'b10, w} || PADDR !== a || PWDATA !== (w ? d : 32'h0)) begin
                errors++; $display("FAIL rnd_setup it=%0d got sel/en/wr=%b%b%b paddr=%h pwdata=%h want wr=%b paddr=%h", it, PSEL, PENABLE, PWRITE, PADDR, PWDATA, w, a); end
            waits = $urandom_range(0, 3); err = 1'($urandom); rd = $urandom;
            for (int k = 0; k <= waits; k++) begin
                tick();
                PREADY  = (k == waits);
                PSLVERR = (k == waits) ? err : 1'($urandom);
                PRDATA  = (k == waits) ? rd : $urandom;
                #1;
                checks++; if ({PSEL, PENABLE} !== 2'b11 || PADDR !== a || rsp_valid !== 4'b0000) begin
                    errors++; $display("FAIL rnd_access it=%0d k=%0d got sel/en=%b%b paddr=%h rsp=%b want 11/%h/0000", it, k, PSEL, PENABLE, PADDR, rsp_valid, a); end
            end
            tick();
            pend = 1'b1; pg = g; p_err = err; p_rdata = w ? 32'h0 : rd;
        end
        req_valid = '0; PREADY = 1'b0; #1;
        if (pend) begin
            checks++; if (rsp_valid !== (NR'(1) << pg) || rsp_rdata !== p_rdata || rsp_err !== p_err) begin
                errors++; $display("FAIL rnd_final got %b/%h/%b want %b/%h/%b", rsp_valid, rsp_rdata, rsp_err, NR'(1) << pg, p_rdata, p_err); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_wait();
        test_fairness();
        test_slverr();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB master that shares a single APB slave port (the `apb_slave_ifc` bus) between `NUM_REQ` local requesters. It arbitrates round-robin, sequences each transfer through the APB SETUP and ACCESS phases, waits on `PREADY` with a bounded timeout, and returns read data and an error flag to the granted requester. It sits between testbench or SoC-side agents and the APB slave DUT, one transfer in flight at a time.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `ADDR_WIDTH`, `` `ADDR_WIDTH ``: APB address width.
- `DATA_WIDTH`, `` `DATA_WIDTH ``: APB data width.
- `TIMEOUT`, 16: maximum ACCESS cycles without `PREADY`; 0 disables the timeout.

Ports:
- `PCLK` in 1: single clock, all state on the rising edge.
- `PRESET` in 1: reset, synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester transfer request.
- `req_write` in NUM_REQ: 1 = write, 0 = read.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i is at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data, sliced the same way.
- `req_ready` out NUM_REQ: one-hot, one-cycle accept pulse.
- `rsp_valid` out NUM_REQ: one-hot, one-cycle completion pulse.
- `rsp_rdata` out DATA_WIDTH: read data, shared by all requesters, qualified by `rsp_valid`.
- `rsp_err` out 1: `PSLVERR` or timeout, qualified by `rsp_valid`.
- `PSEL` out 1, `PENABLE` out 1, `PWRITE` out 1.
- `PADDR` out ADDR_WIDTH, `PWDATA` out DATA_WIDTH.
- `PRDATA` in DATA_WIDTH, `PREADY` in 1, `PSLVERR` in 1.

## Operation
- FSM states `IDLE`, `SETUP`, `ACCESS`.
- `IDLE`:
  - Combinational round-robin over `req_valid`, starting at `last_grant+1` and wrapping modulo NUM_REQ.
  - If any request is valid: `req_ready[g]` = 1 in the same cycle. On the edge, capture write/addr/wdata for g, set `last_grant` = g and go to `SETUP`.
- `SETUP`: `PSEL`=1, `PENABLE`=0, address, control and write data driven from the capture registers. Always go to `ACCESS` next.
- `ACCESS`: `PSEL`=1, `PENABLE`=1, bus signals held stable.
  - `PREADY`=1: complete and go to `IDLE`.
  - Otherwise increment the wait counter. When the counter reaches `TIMEOUT` (nonzero), abort and go to `IDLE`.
- Completion (registered, asserted in the following `IDLE` cycle):
  - `rsp_valid[g]`=1.
  - `rsp_rdata` = `PRDATA` for a read, 0 for a write or a timeout.
  - `rsp_err` = `PSLVERR` on normal completion, 1 on timeout.
- Requesters hold `req_*` stable while `req_valid`=1 until `req_ready`. After acceptance they may change them freely, because the fields are already captured.
- `req_valid` dropped before acceptance is legal and ignored. Nothing is queued.
- `PWDATA` = 0 for reads. `PADDR`/`PWRITE`/`PWDATA` = 0 while `PSEL`=0.

## Timing
- Reset values: all outputs 0, state `IDLE`, wait counter 0, `last_grant` = NUM_REQ-1, so requester 0 has first priority.
- Accept in cycle T, SETUP at T+1, ACCESS at T+2.
- With zero wait states, `PREADY` is sampled at T+2 and `rsp_valid` is asserted at T+3. The cycle at T+3 is also `IDLE` and may accept the next request. Peak rate is one transfer per 3 cycles.
- Each wait state adds 1 cycle.
- Timeout: after `TIMEOUT` ACCESS cycles without `PREADY`, `PSEL`/`PENABLE` drop on the next edge. A `PREADY` arriving after that is ignored.
- `PREADY` in the same ACCESS cycle in which the counter hits the limit: normal completion wins, with `rsp_err` = `PSLVERR`.
- `PREADY`/`PSLVERR` are ignored outside `ACCESS`.
- `PRESET` mid-transfer: all outputs return to 0 on the next edge. No `rsp_valid` is ever issued for the aborted transfer, and `last_grant` resets.
- Wait counter width is $clog2(TIMEOUT+1). It clears on every entry to `SETUP`.

## Structure
- `apb_pkg` holds `typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e` and the widths from `defines.sv`.
- Sub-module `apb_rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs: req vector, `last_grant` index.
  - Outputs: one-hot grant, grant index, any-valid.
  - Purely combinational. `apb_master_arbiter` owns the pointer register and the FSM.
- The master connects to the bus through the interface's driver-side signals. It does not use the slave modport.

## Test plan
- Single read, zero wait: req0 reads 0x10 and the slave returns 0xDEADBEEF with `PREADY`=1 at once → `req_ready[0]` at T, SETUP at T+1, ACCESS at T+2, `rsp_valid[0]` with `rsp_rdata`=0xDEADBEEF and `rsp_err`=0 at T+3.
- Write with 2 wait states: req2 writes 0xA5A5A5A5 to 0x24 → `PENABLE` high for 3 cycles, `PWDATA` stable throughout, `rsp_valid[2]` at T+5, `rsp_rdata`=0.
- Fairness: all 4 requesters valid continuously from reset → grant order 0,1,2,3,0, one accept every 3 cycles.
- Timeout: `TIMEOUT`=16 and `PREADY` never rises → `PSEL` drops after 16 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0. A late `PREADY` is ignored.
- Slave error: `PSLVERR`=1 with `PREADY` on a read → `rsp_err`=1 and `rsp_rdata` = `PRDATA`.
- Reset mid-ACCESS: `PRESET` pulsed during a wait state → all outputs 0 next edge, no `rsp_valid`, next grant goes to requester 0.
